// File: rtl/pdu_pkg.sv
// Shared constants for the hex keypad entry path: key codes, debounce FSM
// state encodings and the key-code to action decode.
package pdu_pkg;

    localparam logic [4:0] KEY_BKSP  = 5'd16;
    localparam logic [4:0] KEY_CLR   = 5'd17;
    localparam logic [4:0] KEY_ENTER = 5'd18;

    localparam logic [0:0] ST_IDLE     = 1'b0;
    localparam logic [0:0] ST_WAIT_REL = 1'b1;

    typedef enum logic [2:0] {
        ACT_NONE,
        ACT_DIGIT,
        ACT_BKSP,
        ACT_CLR,
        ACT_ENTER
    } action_e;

    // Codes 19..31 fall through to ACT_NONE: consumed as a press, no effect.
    function automatic action_e decode_action(input logic [4:0] code);
        action_e act;
        act = ACT_NONE;
        if (!code[4])               act = ACT_DIGIT;
        else if (code == KEY_BKSP)  act = ACT_BKSP;
        else if (code == KEY_CLR)   act = ACT_CLR;
        else if (code == KEY_ENTER) act = ACT_ENTER;
        return act;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Debounces the raw key level and emits a single press pulse per recognised
// press; the pulse is combinational so the action lands on the accepting edge.
//
//   state       | meaning
//   ------------+------------------------------------------------------
//   ST_IDLE     | waiting for DEB_CYCLES consecutive key_press=1 samples
//   ST_WAIT_REL | press accepted, waiting for DEB_CYCLES consecutive 0s
module key_debounce
    import pdu_pkg::*;
#(
    parameter int DEB_CYCLES = 4
) (
    input  logic clkd,
    input  logic rstn,
    input  logic key_press,
    output logic press_pulse
);

    localparam logic [3:0] CNT_LAST = 4'(DEB_CYCLES - 1);

    logic [0:0] state_q, state_d;
    logic [3:0] cnt_q, cnt_d;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        press_pulse = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (key_press) begin
                    if (cnt_q == CNT_LAST) begin
                        press_pulse = 1'b1;
                        state_d     = ST_WAIT_REL;
                        cnt_d       = 4'd0;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end else begin
                    cnt_d = 4'd0;
                end
            end
            ST_WAIT_REL: begin
                if (!key_press) begin
                    if (cnt_q == CNT_LAST) begin
                        state_d = ST_IDLE;
                        cnt_d   = 4'd0;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end else begin
                    cnt_d = 4'd0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clkd or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/hex_entry_buffer.sv
// Hex keypad entry buffer: applies one action per debounced press and hands
// the committed value to a consumer through a valid/ready register.
module hex_entry_buffer
    import pdu_pkg::*;
#(
    parameter int DEB_CYCLES = 4,
    parameter int MAX_DIGITS = 8
) (
    input  logic        clkd,
    input  logic        rstn,
    input  logic        key_press,
    input  logic [4:0]  key_code,
    output logic [31:0] disp_word,
    output logic [3:0]  digit_cnt,
    output logic        full,
    output logic [31:0] data,
    output logic        data_valid,
    input  logic        data_ready
);

    localparam logic [3:0] MAX_CNT = 4'(MAX_DIGITS);

    logic        press_pulse;
    logic [31:0] buffer_q, buffer_d;
    logic [3:0]  digit_cnt_q, digit_cnt_d;
    logic [31:0] data_q, data_d;
    logic        data_valid_q, data_valid_d;

    key_debounce #(
        .DEB_CYCLES (DEB_CYCLES)
    ) u_key_debounce (
        .clkd        (clkd),
        .rstn        (rstn),
        .key_press   (key_press),
        .press_pulse (press_pulse)
    );

    always_comb begin
        buffer_d     = buffer_q;
        digit_cnt_d  = digit_cnt_q;
        data_d       = data_q;
        data_valid_d = data_valid_q;

        if (data_valid_q && data_ready) data_valid_d = 1'b0;

        // An enter accepted on the consume edge reloads data and keeps valid high.
        if (press_pulse) begin
            case (decode_action(key_code))
                ACT_DIGIT: begin
                    if (digit_cnt_q < MAX_CNT) begin
                        buffer_d    = {buffer_q[27:0], key_code[3:0]};
                        digit_cnt_d = digit_cnt_q + 4'd1;
                    end
                end
                ACT_BKSP: begin
                    if (digit_cnt_q != 4'd0) begin
                        buffer_d    = {4'h0, buffer_q[31:4]};
                        digit_cnt_d = digit_cnt_q - 4'd1;
                    end
                end
                ACT_CLR: begin
                    buffer_d    = 32'd0;
                    digit_cnt_d = 4'd0;
                end
                ACT_ENTER: begin
                    if (!data_valid_q || data_ready) begin
                        data_d       = buffer_q;
                        data_valid_d = 1'b1;
                        buffer_d     = 32'd0;
                        digit_cnt_d  = 4'd0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clkd or negedge rstn) begin
        if (!rstn) begin
            buffer_q     <= 32'd0;
            digit_cnt_q  <= 4'd0;
            data_q       <= 32'd0;
            data_valid_q <= 1'b0;
        end else begin
            buffer_q     <= buffer_d;
            digit_cnt_q  <= digit_cnt_d;
            data_q       <= data_d;
            data_valid_q <= data_valid_d;
        end
    end

    assign disp_word  = buffer_q;
    assign digit_cnt  = digit_cnt_q;
    assign full       = (digit_cnt_q == MAX_CNT);
    assign data       = data_q;
    assign data_valid = data_valid_q;

endmodule

// File: tb/tb_hex_entry_buffer.sv
// Self-checking bench for hex_entry_buffer: a table of key presses with
// expected outputs, plus hand-written debounce, handshake and reset sequences.
module tb_hex_entry_buffer;

    localparam int DEB = 4;

    logic        clkd;
    logic        rstn;
    logic        key_press;
    logic [4:0]  key_code;
    logic [31:0] disp_word;
    logic [3:0]  digit_cnt;
    logic        full;
    logic [31:0] data;
    logic        data_valid;
    logic        data_ready;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] disp;
        logic [3:0]  cnt;
        logic        full;
        logic [31:0] data;
        logic        valid;
    } exp_t;

    typedef struct {
        logic [4:0] code;
        logic       ready;
        exp_t       exp;
    } vec_t;

    exp_t sb_q[$];
    vec_t vecs[25];

    hex_entry_buffer #(
        .DEB_CYCLES (DEB),
        .MAX_DIGITS (8)
    ) dut (
        .clkd       (clkd),
        .rstn       (rstn),
        .key_press  (key_press),
        .key_code   (key_code),
        .disp_word  (disp_word),
        .digit_cnt  (digit_cnt),
        .full       (full),
        .data       (data),
        .data_valid (data_valid),
        .data_ready (data_ready)
    );

    initial clkd = 1'b0;
    always #5 clkd = ~clkd;

    task automatic tick();
        @(posedge clkd);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string name, input exp_t e);
        chk({name, ".disp"},  disp_word,          e.disp);
        chk({name, ".cnt"},   32'(digit_cnt),     32'(e.cnt));
        chk({name, ".full"},  32'(full),          32'(e.full));
        chk({name, ".data"},  data,               e.data);
        chk({name, ".valid"}, 32'(data_valid),    32'(e.valid));
    endtask

    function automatic vec_t mk(input logic [4:0] code, input logic ready,
                                input logic [31:0] disp, input logic [3:0] cnt,
                                input logic f, input logic [31:0] d, input logic v);
        vec_t r;
        r.code      = code;
        r.ready     = ready;
        r.exp.disp  = disp;
        r.exp.cnt   = cnt;
        r.exp.full  = f;
        r.exp.data  = d;
        r.exp.valid = v;
        return r;
    endfunction

    // data_ready is only raised on the accepting (DEB-th) edge of the hold.
    task automatic press(input logic [4:0] code, input int hold, input logic ready);
        key_code  = code;
        key_press = 1'b1;
        for (int i = 1; i <= hold; i++) begin
            data_ready = (i == DEB) ? ready : 1'b0;
            tick();
        end
        data_ready = 1'b0;
        key_press  = 1'b0;
        repeat (DEB) tick();
    endtask

    initial begin
        exp_t e;
        vecs[0]  = mk(5'd17, 0, 32'h0,        4'd0, 0, 32'h0,    0);
        vecs[1]  = mk(5'd1,  0, 32'h1,        4'd1, 0, 32'h0,    0);
        vecs[2]  = mk(5'd2,  0, 32'h12,       4'd2, 0, 32'h0,    0);
        vecs[3]  = mk(5'd3,  0, 32'h123,      4'd3, 0, 32'h0,    0);
        vecs[4]  = mk(5'd4,  0, 32'h1234,     4'd4, 0, 32'h0,    0);
        vecs[5]  = mk(5'd5,  0, 32'h12345,    4'd5, 0, 32'h0,    0);
        vecs[6]  = mk(5'd6,  0, 32'h123456,   4'd6, 0, 32'h0,    0);
        vecs[7]  = mk(5'd7,  0, 32'h1234567,  4'd7, 0, 32'h0,    0);
        vecs[8]  = mk(5'd8,  0, 32'h12345678, 4'd8, 1, 32'h0,    0);
        vecs[9]  = mk(5'd9,  0, 32'h12345678, 4'd8, 1, 32'h0,    0);
        vecs[10] = mk(5'd16, 0, 32'h01234567, 4'd7, 0, 32'h0,    0);
        vecs[11] = mk(5'd17, 0, 32'h0,        4'd0, 0, 32'h0,    0);
        vecs[12] = mk(5'd11, 0, 32'hB,        4'd1, 0, 32'h0,    0);
        vecs[13] = mk(5'd14, 0, 32'hBE,       4'd2, 0, 32'h0,    0);
        vecs[14] = mk(5'd14, 0, 32'hBEE,      4'd3, 0, 32'h0,    0);
        vecs[15] = mk(5'd15, 0, 32'hBEEF,     4'd4, 0, 32'h0,    0);
        vecs[16] = mk(5'd18, 0, 32'h0,        4'd0, 0, 32'hBEEF, 1);
        vecs[17] = mk(5'd1,  0, 32'h1,        4'd1, 0, 32'hBEEF, 1);
        vecs[18] = mk(5'd18, 0, 32'h1,        4'd1, 0, 32'hBEEF, 1);
        vecs[19] = mk(5'd20, 0, 32'h1,        4'd1, 0, 32'hBEEF, 1);
        vecs[20] = mk(5'd16, 0, 32'h0,        4'd0, 0, 32'hBEEF, 1);
        vecs[21] = mk(5'd16, 0, 32'h0,        4'd0, 0, 32'hBEEF, 1);
        vecs[22] = mk(5'd1,  0, 32'h1,        4'd1, 0, 32'hBEEF, 1);
        vecs[23] = mk(5'd2,  0, 32'h12,       4'd2, 0, 32'hBEEF, 1);
        vecs[24] = mk(5'd18, 1, 32'h0,        4'd0, 0, 32'h12,   1);

        rstn       = 1'b0;
        key_press  = 1'b0;
        key_code   = 5'd0;
        data_ready = 1'b0;
        #12;
        e = '{disp: 32'h0, cnt: 4'd0, full: 1'b0, data: 32'h0, valid: 1'b0};
        chk_all("reset", e);
        rstn = 1'b1;

        // Short hold (DEB-1 samples) must not register; a full run must.
        key_code  = 5'hA;
        key_press = 1'b1;
        repeat (DEB - 1) tick();
        chk("short_hold.disp", disp_word, 32'h0);
        key_press = 1'b0;
        tick();
        key_press = 1'b1;
        repeat (DEB - 1) tick();
        chk("pre_accept.disp", disp_word, 32'h0);
        tick();
        chk("accept.disp", disp_word, 32'h0000000A);
        chk("accept.cnt", 32'(digit_cnt), 32'd1);
        key_press = 1'b0;
        repeat (DEB) tick();

        for (int i = 0; i < 25; i++) begin
            exp_t got;
            sb_q.push_back(vecs[i].exp);
            press(vecs[i].code, DEB + (i % 3), vecs[i].ready);
            got = sb_q.pop_front();
            chk_all($sformatf("vec%0d", i), got);
        end

        // One-cycle consume drops valid; data stays put.
        data_ready = 1'b1;
        tick();
        data_ready = 1'b0;
        chk("consume.valid", 32'(data_valid), 32'd0);
        chk("consume.data", data, 32'h12);

        // Bounce then long hold: exactly one digit entered.
        key_code  = 5'd5;
        key_press = 1'b1; tick();
        key_press = 1'b0; tick();
        key_press = 1'b1;
        repeat (DEB - 1) tick();
        chk("bounce_pre.cnt", 32'(digit_cnt), 32'd0);
        tick();
        chk("bounce.disp", disp_word, 32'h5);
        repeat (100) tick();
        chk("long_hold.disp", disp_word, 32'h5);
        chk("long_hold.cnt", 32'(digit_cnt), 32'd1);
        key_press = 1'b0;
        repeat (DEB) tick();

        // Reset while held in WAIT_REL; held key re-registers after DEB edges.
        key_code  = 5'd7;
        key_press = 1'b1;
        repeat (DEB) tick();
        chk("pre_rst.disp", disp_word, 32'h57);
        repeat (2) tick();
        #2 rstn = 1'b0;
        #1;
        chk_all("async_rst", '{disp: 32'h0, cnt: 4'd0, full: 1'b0, data: 32'h0, valid: 1'b0});
        tick();
        rstn = 1'b1;
        repeat (DEB - 1) tick();
        chk("post_rst_pre.disp", disp_word, 32'h0);
        tick();
        chk("post_rst.disp", disp_word, 32'h7);
        chk("post_rst.cnt", 32'(digit_cnt), 32'd1);
        key_press = 1'b0;
        repeat (DEB) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hex_entry_buffer.md
HEX_ENTRY_BUFFER -- requirements
Module: hex_entry_buffer

Interface
REQ-001 The block SHALL have parameter DEB_CYCLES, default 4, meaning the number of consecutive clkd samples needed to accept a press or release (legal range 2..15).
REQ-002 The block SHALL have parameter MAX_DIGITS, default 8, meaning the maximum number of hex digits held (legal range 1..8).
REQ-003 The block SHALL have port clkd, input, 1 bit: the divided scan clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rstn, input, 1 bit: reset, asynchronous, active-low.
REQ-005 The block SHALL have port key_press, input, 1 bit: raw, undebounced button level.
REQ-006 The block SHALL have port key_code, input, 5 bits: 0-15 hex digit, 16 backspace, 17 clear, 18 enter, 19-31 reserved.
REQ-007 The block SHALL have port disp_word, output, 32 bits: the entry buffer, driving the 7-segment scanner input.
REQ-008 The block SHALL have port digit_cnt, output, 4 bits: the number of digits currently entered.
REQ-009 The block SHALL have port full, output, 1 bit: asserted while digit_cnt equals MAX_DIGITS.
REQ-010 The block SHALL have port data, output, 32 bits: the committed value.
REQ-011 The block SHALL have port data_valid, output, 1 bit: asserted while data holds an unconsumed committed value.
REQ-012 The block SHALL have port data_ready, input, 1 bit: the consumer accepts data.

Function
REQ-013 The FSM SHALL have states IDLE (await press) and WAIT_REL (await release).
REQ-014 In IDLE, a stable counter SHALL increment on each edge with key_press=1 and clear on any edge with key_press=0.
REQ-015 On the edge where key_press is sampled 1 for the DEB_CYCLES-th consecutive time, key_code SHALL be sampled on that edge, its action applied, and the FSM moved to WAIT_REL with the counter cleared.
REQ-016 In WAIT_REL, the counter SHALL count consecutive key_press=0 samples and clear on any 1; at DEB_CYCLES consecutive 0 samples the FSM SHALL return to IDLE with the counter cleared.
REQ-017 Exactly one action SHALL be applied per recognised press, regardless of hold length.
REQ-018 Digit action: if digit_cnt<MAX_DIGITS, the buffer SHALL become {buffer[27:0],code[3:0]} and digit_cnt SHALL increment; otherwise the press is ignored with no change.
REQ-019 Backspace action: if digit_cnt>0, the buffer SHALL become {4'h0,buffer[31:4]} and digit_cnt SHALL decrement; if digit_cnt=0, nothing changes.
REQ-020 Clear action: the buffer and digit_cnt SHALL be set to 0.
REQ-021 Enter action, when data_valid=0 or data_ready=1 on the same edge: data SHALL take the buffer value, data_valid SHALL be 1, and the buffer and digit_cnt SHALL be cleared.
REQ-022 Enter action, when data_valid=1 and data_ready=0: the press SHALL be ignored, with the buffer and data unchanged.
REQ-023 Reserved codes SHALL be consumed as presses with no effect.
REQ-024 data_valid SHALL fall on the edge where data_valid=1 and data_ready=1, unless REQ-021 reloads data on that same edge.
REQ-025 data SHALL hold stable while data_valid=1.
REQ-026 disp_word SHALL equal the buffer combinationally, with zero added latency.
REQ-027 full SHALL be a combinational compare of digit_cnt against MAX_DIGITS.

Reset
REQ-028 rstn=0 SHALL immediately force: FSM to IDLE, counter 0, buffer/disp_word 0, digit_cnt 0, data 0, data_valid 0.
REQ-029 A reset mid-debounce or mid-hold SHALL discard the pending press; after release of reset a held key SHALL need a full DEB_CYCLES run to be recognised.

Structure
REQ-030 The key-code constants (16/17/18) and the FSM state encodings SHALL reside in shared package pdu_pkg.
REQ-031 The debounce counter and the press/release recognition SHALL be sub-module key_debounce, emitting a one-cycle press pulse; action and handshake logic SHALL stay in hex_entry_buffer.

Verification
REQ-032 Test: hold key_press for 3 cycles with DEB_CYCLES=4 -> no change; then hold for 4 cycles with code 0xA -> disp_word=0x0000000A, digit_cnt=1 on the 4th edge.
REQ-033 Test: enter 1..8, then 9 -> disp_word=0x12345678, full=1, and the 9 is ignored; then backspace -> 0x01234567, digit_cnt=7.
REQ-034 Test: enter 0xBEEF, then press enter with data_ready=0 -> data=0x0000BEEF, data_valid=1, disp_word=0; a second enter is ignored; raising data_ready for 1 cycle -> data_valid=0.
REQ-035 Test: press enter on the same edge that data_valid=1 and data_ready=1 -> data takes the new value and data_valid stays 1.
REQ-036 Test: pulse rstn low while a key is held in WAIT_REL -> all outputs 0; the key still held after reset registers after 4 edges.
REQ-037 Test: key bounces 1,0,1,1,1,1 -> exactly one action; holding for 100 cycles -> still exactly one action.
